// File: rtl/shot_clock_pkg.sv
// shot_clock_pkg: shared state type and timing helpers for the shot-clock expiry buzzer.
package shot_clock_pkg;

    typedef enum logic [1:0] {IDLE, BEEP, GAP, DONE} buz_state_t;

    function automatic int half_of(input int clk_hz, input int tone_hz);
        return clk_hz / (2 * tone_hz) - 1;
    endfunction

    function automatic int half2_of(input int clk_hz, input int tone_hz);
        return clk_hz / (4 * tone_hz) - 1;
    endfunction

    function automatic int cyc_of(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/shot_clock_buzzer_tone_gen.sv
// tone_gen: square wave with a programmable half period; held low and cleared while disabled.
// The tone output is the level the internal flop takes on the next clock.
module tone_gen #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] half_limit,
    output logic         tone
);

    logic [W-1:0] cnt;
    logic         tone_q;
    logic         wrap;

    assign wrap = cnt == half_limit;
    assign tone = en & (tone_q ^ wrap);

    // Count 0..half_limit and toggle on wrap; restart from a low phase whenever disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt    <= (en && !wrap) ? cnt + 1'b1 : '0;
            tone_q <= tone;
        end
    end

endmodule

// File: rtl/shot_clock_buzzer.sv
// shot_clock_buzzer: plays a burst of NUM_BEEPS beeps on each rising edge of the countdown's 00 level.
// Optional SHOT_BUZZER_TWO_TONE_EN: odd-index beeps sound one octave higher.
module shot_clock_buzzer
    import shot_clock_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int TONE_HZ   = 2000,
    parameter int BEEP_MS   = 300,
    parameter int GAP_MS    = 200,
    parameter int NUM_BEEPS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       expire,
    input  logic       mute,
    output logic       buzzer,
    output logic       busy,
    output logic [2:0] beep_idx
);

    localparam int HALF     = half_of(CLK_HZ, TONE_HZ);
    localparam int BEEP_CYC = cyc_of(CLK_HZ, BEEP_MS);
    localparam int GAP_CYC  = cyc_of(CLK_HZ, GAP_MS);
    localparam int DMAX     = BEEP_CYC > GAP_CYC ? BEEP_CYC : GAP_CYC;
    localparam int DW       = $clog2(DMAX + 1);
    localparam int HW       = HALF > 0 ? $clog2(HALF + 1) : 1;

    buz_state_t    state;
    logic [DW-1:0] dur_cnt;
    logic          expire_d;
    logic          rise;
    logic          beep_end;
    logic          gap_end;
    logic          tone_en;
    logic          tone;
    logic [HW-1:0] half_limit;

    assign rise     = expire & ~expire_d;
    assign beep_end = state == BEEP && dur_cnt == DW'(BEEP_CYC - 1);
    assign gap_end  = state == GAP && dur_cnt == DW'(GAP_CYC - 1);
    assign tone_en  = state == BEEP;

`ifdef SHOT_BUZZER_TWO_TONE_EN
    localparam int HALF2 = half2_of(CLK_HZ, TONE_HZ);
    assign half_limit = beep_idx[0] ? HW'(HALF2) : HW'(HALF);
`else
    assign half_limit = HW'(HALF);
`endif

    tone_gen #(.W(HW)) u_tone (
        .clk        (clk),
        .rst        (rst),
        .en         (tone_en),
        .half_limit (half_limit),
        .tone       (tone)
    );

    // Burst sequencer; beep_idx doubles as the beep counter and is cleared on leaving the burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dur_cnt  <= '0;
            beep_idx <= '0;
            busy     <= 1'b0;
            expire_d <= 1'b1;
        end else begin
            expire_d <= expire;
            case (state)
                IDLE: if (rise) begin
                    state    <= BEEP;
                    dur_cnt  <= '0;
                    beep_idx <= '0;
                    busy     <= 1'b1;
                end
                BEEP: if (beep_end) begin
                    dur_cnt <= '0;
                    if (beep_idx == 3'(NUM_BEEPS - 1)) begin
                        state    <= DONE;
                        beep_idx <= '0;
                        busy     <= 1'b0;
                    end else begin
                        state <= GAP;
                    end
                end else begin
                    dur_cnt <= dur_cnt + 1'b1;
                end
                GAP: if (gap_end) begin
                    state    <= BEEP;
                    dur_cnt  <= '0;
                    beep_idx <= beep_idx + 3'd1;
                end else begin
                    dur_cnt <= dur_cnt + 1'b1;
                end
                DONE: if (!expire) state <= IDLE;
            endcase
        end
    end

    // Buzzer pin: tone with mute applied, forced low on a beep's last cycle so no edge leaks into the gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) buzzer <= 1'b0;
        else     buzzer <= tone & ~mute & ~beep_end;
    end

endmodule
